// File: rtl/vpe_var_sweep_ctrl_pkg.sv
// Shared types, default sizing and helpers for the VPE variable-sweep sequencer.
package vpe_var_sweep_ctrl_pkg;

  localparam int NV_DEF     = 60;
  localparam int ITER_W_DEF = 16;
  localparam int SETTLE_DEF = 2;
  localparam int IDX_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SELECT  = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_CHECK   = 3'd5,
    ST_FIN     = 3'd6
  } state_t;

  // One-hot word-line row select for variable idx.
  function automatic logic [NV_DEF-1:0] onehot_sel(input logic [IDX_W-1:0] idx);
    logic [NV_DEF-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/vpe_var_reg.sv
// Variable assignment register: parallel load, single-bit write-back, bit read mux.
module vpe_var_reg
  import vpe_var_sweep_ctrl_pkg::*;
#(
  parameter int NV = NV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [NV-1:0]    load_val,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             wr_data,
  output logic [NV-1:0]    v,
  output logic             v_bit
);

  logic [NV-1:0] v_reg;
  logic [NV-1:0] v_next;

  // Each bit either reloads, takes the slave readout when addressed, or holds.
  genvar gi;
  generate
    for (gi = 0; gi < NV; gi++) begin : g_bit
      assign v_next[gi] = load_en ? load_val[gi]
                        : ((wr_en && (idx == IDX_W'(gi))) ? wr_data : v_reg[gi]);
    end
  endgenerate

  // Assignment storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_reg <= '0;
    else        v_reg <= v_next;
  end

  assign v     = v_reg;
  assign v_bit = v_reg[idx];

endmodule

// File: rtl/vpe_var_sweep_ctrl.sv
// Sweeps the variables of the VPE slave array one at a time until SATISFY or budget end.
module vpe_var_sweep_ctrl
  import vpe_var_sweep_ctrl_pkg::*;
#(
  parameter int NV     = NV_DEF,
  parameter int ITER_W = ITER_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [NV-1:0]     V_INIT,
  input  logic [IDX_W-1:0]  VAR_NUM,
  input  logic [ITER_W-1:0] MAX_ITER,
  input  logic              VI_READOUT,
  input  logic              SATISFY,
  output logic [NV-1:0]     V,
  output logic [NV-1:0]     WL_SW,
  output logic              WL_SIGN,
  output logic              VUL_EN,
  output logic              V_PRE,
  output logic              VAR_STATE,
  output logic              SRAM_STATE,
  output logic              BUSY,
  output logic              DONE,
  output logic              SOLVED,
  output logic [ITER_W-1:0] ITER_CNT
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [3:0]        settle_reg, settle_next;
  logic              first_reg, first_next;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic [ITER_W-1:0] max_reg, max_next;
  logic [ITER_W-1:0] iter_inc;
  logic [NV-1:0]     init_reg, init_next;
  logic              solved_reg, solved_next;
  logic              v_pre_reg, v_pre_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              var_state_reg, sram_state_reg;
  logic [IDX_W-1:0]  var_num_last;
  logic [NV_DEF-1:0] row_sel;
  logic              selecting;
  logic              v_bit;
  logic              var_load, var_wr;

  // Out-of-range variable counts fall back to the full array.
  always_comb begin
    if (VAR_NUM == '0 || int'(VAR_NUM) > NV) var_num_last = IDX_W'(NV - 1);
    else                                     var_num_last = VAR_NUM - IDX_W'(1);
  end

  assign iter_inc = (&iter_reg) ? iter_reg : iter_reg + ITER_W'(1);

  // Next-state logic: sequencing, latching and sweep bookkeeping.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    last_next   = last_reg;
    settle_next = settle_reg;
    first_next  = first_reg;
    iter_next   = iter_reg;
    max_next    = max_reg;
    init_next   = init_reg;
    solved_next = solved_reg;
    v_pre_next  = v_pre_reg;
    if (ABORT && state_reg != ST_IDLE) begin
      state_next  = ST_IDLE;
      solved_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START && !ABORT) begin
            state_next  = ST_LOAD;
            init_next   = V_INIT;
            last_next   = var_num_last;
            max_next    = MAX_ITER;
            iter_next   = '0;
            solved_next = 1'b0;
          end
        end
        ST_LOAD: begin
          idx_next    = '0;
          settle_next = '0;
          first_next  = 1'b1;
          state_next  = ST_SELECT;
        end
        ST_SELECT: begin
          if (settle_reg == SETTLE_LAST) begin
            settle_next = '0;
            first_next  = 1'b0;
            if (first_reg && SATISFY) begin
              // Initial assignment already satisfies every clause.
              solved_next = 1'b1;
              state_next  = ST_FIN;
            end else begin
              v_pre_next = v_bit;
              state_next = ST_UPDATE;
            end
          end else begin
            settle_next = settle_reg + 4'd1;
          end
        end
        ST_UPDATE:  state_next = ST_CAPTURE;
        ST_CAPTURE: state_next = ST_CHECK;
        ST_CHECK: begin
          if (SATISFY) begin
            solved_next = 1'b1;
            state_next  = ST_FIN;
          end else if (idx_reg == last_reg) begin
            idx_next   = '0;
            iter_next  = iter_inc;
            state_next = (iter_inc > max_reg) ? ST_FIN : ST_SELECT;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = ST_SELECT;
          end
        end
        ST_FIN:  state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy_next = state_next inside {ST_LOAD, ST_SELECT, ST_UPDATE, ST_CAPTURE, ST_CHECK};
  assign done_next = (state_next == ST_FIN);

  // State and registered status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      last_reg       <= '0;
      settle_reg     <= '0;
      first_reg      <= 1'b0;
      iter_reg       <= '0;
      max_reg        <= '0;
      init_reg       <= '0;
      solved_reg     <= 1'b0;
      v_pre_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      var_state_reg  <= 1'b0;
      sram_state_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      last_reg       <= last_next;
      settle_reg     <= settle_next;
      first_reg      <= first_next;
      iter_reg       <= iter_next;
      max_reg        <= max_next;
      init_reg       <= init_next;
      solved_reg     <= solved_next;
      v_pre_reg      <= v_pre_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      var_state_reg  <= busy_next;
      sram_state_reg <= ~busy_next;
    end
  end

  // An abort in the same cycle must not disturb V.
  assign var_load = (state_reg == ST_LOAD) && !ABORT;
  assign var_wr   = (state_reg == ST_CAPTURE) && !ABORT;

  vpe_var_reg #(.NV(NV)) u_var_reg (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load_en  (var_load),
    .load_val (init_reg),
    .wr_en    (var_wr),
    .idx      (idx_reg),
    .wr_data  (VI_READOUT),
    .v        (V),
    .v_bit    (v_bit)
  );

  assign selecting  = state_reg inside {ST_SELECT, ST_UPDATE, ST_CAPTURE};
  assign row_sel    = onehot_sel(idx_reg);
  assign WL_SW      = selecting ? NV'(row_sel) : '0;
  assign WL_SIGN    = selecting & v_bit;
  assign VUL_EN     = (state_reg == ST_UPDATE);
  assign V_PRE      = v_pre_reg;
  assign VAR_STATE  = var_state_reg;
  assign SRAM_STATE = sram_state_reg;
  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign SOLVED     = solved_reg;
  assign ITER_CNT   = iter_reg;

endmodule

// File: tb/tb_vpe_var_sweep_ctrl.sv
// Self-checking bench for the VPE variable-sweep sequencer; slave flips each variable.
module tb_vpe_var_sweep_ctrl;

  localparam int NV     = 60;
  localparam int ITER_W = 16;
  localparam logic [NV-1:0] ONE  = NV'(1);
  localparam logic [NV-1:0] ALL1 = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              satisfy = 1'b0;
  logic [NV-1:0]     v_init = '0;
  logic [5:0]        var_num = 6'd4;
  logic [ITER_W-1:0] max_iter = '0;
  logic              vi_readout;
  logic [NV-1:0]     v, wl_sw;
  logic              wl_sign, vul_en, v_pre, var_state, sram_state, busy, done, solved;
  logic [ITER_W-1:0] iter_cnt;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Slave model: the updated value is the inverse of the previous one.
  assign vi_readout = ~v_pre;

  vpe_var_sweep_ctrl #(.NV(NV), .ITER_W(ITER_W), .SETTLE(2)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .START      (start),
    .ABORT      (abort),
    .V_INIT     (v_init),
    .VAR_NUM    (var_num),
    .MAX_ITER   (max_iter),
    .VI_READOUT (vi_readout),
    .SATISFY    (satisfy),
    .V          (v),
    .WL_SW      (wl_sw),
    .WL_SIGN    (wl_sign),
    .VUL_EN     (vul_en),
    .V_PRE      (v_pre),
    .VAR_STATE  (var_state),
    .SRAM_STATE (sram_state),
    .BUSY       (busy),
    .DONE       (done),
    .SOLVED     (solved),
    .ITER_CNT   (iter_cnt)
  );

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (v !== '0) begin failures++; $display("FAIL reset_v got=%h exp=0", v); end
    checks++;
    if (wl_sw !== '0) begin failures++; $display("FAIL reset_wl_sw got=%h exp=0", wl_sw); end
    checks++;
    if ({wl_sign, vul_en, v_pre, var_state, busy, done, solved} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000", {wl_sign, vul_en, v_pre, var_state, busy, done, solved});
    end
    checks++;
    if (sram_state !== 1'b1) begin failures++; $display("FAIL reset_sram_state got=%b exp=1", sram_state); end
    checks++;
    if (iter_cnt !== '0) begin failures++; $display("FAIL reset_iter_cnt got=%0d exp=0", iter_cnt); end
    $display("reset: released, idle 5 cycles");
  endtask

  task automatic test_presat();
    int k = 0;
    int vul_cnt = 0;
    bit got_done = 0;
    bit saw_row0 = 0;
    v_init = 60'h123; var_num = 6'd4; max_iter = '0; satisfy = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || sram_state !== 1'b0 || var_state !== 1'b1) begin
      failures++; $display("FAIL presat_busy got=%b%b%b exp=101", busy, sram_state, var_state);
    end
    while (!got_done && k < 50) begin
      @(negedge clk); k++;
      if (vul_en) vul_cnt++;
      if (wl_sw === ONE) saw_row0 = 1;
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || k != 3) begin failures++; $display("FAIL presat_done_latency got=%0d done=%0b exp=3", k, got_done); end
    checks++;
    if (vul_cnt != 0) begin failures++; $display("FAIL presat_vul_count got=%0d exp=0", vul_cnt); end
    checks++;
    if (!saw_row0) begin failures++; $display("FAIL presat_row0 got=0 exp=1"); end
    checks++;
    if (solved !== 1'b1 || iter_cnt !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL presat_result got solved=%b iter=%0d busy=%b exp 1/0/0", solved, iter_cnt, busy);
    end
    checks++;
    if (v !== 60'h123) begin failures++; $display("FAIL presat_v got=%h exp=123", v); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || solved !== 1'b1 || sram_state !== 1'b1) begin
      failures++; $display("FAIL presat_after got done=%b solved=%b sram=%b exp 0/1/1", done, solved, sram_state);
    end
    satisfy = 1'b0;
    $display("presat: done after %0d cycles solved=%0b v=%h", k, solved, v);
  endtask

  task automatic test_sweep();
    int k = 0;
    int last_vul = -1;
    int run = 0;
    int e;
    bit got_done = 0;
    logic [NV-1:0] prev_sw = '0;
    v_init = 60'hA5A_5A5A_5A5A_5A5A; var_num = 6'd4; max_iter = '0; satisfy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    pulse_start();
    while (!got_done && k < 100) begin
      @(negedge clk); k++;
      if (wl_sw !== prev_sw) begin
        if (prev_sw !== '0) begin
          checks++;
          if (run != 4) begin failures++; $display("FAIL sweep_row_hold row=%h got=%0d exp=4", prev_sw, run); end
        end
        run = 0;
      end
      if (wl_sw !== '0) run++;
      prev_sw = wl_sw;
      if (vul_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sweep_extra_vul got_row=%h exp=none", wl_sw);
        end else begin
          e = exp_q.pop_front();
          if (wl_sw !== (ONE << e) || v_pre !== v_init[e] || wl_sign !== v_init[e]) begin
            failures++;
            $display("FAIL sweep_update got row=%h vpre=%b sign=%b exp row=%h bit=%b", wl_sw, v_pre, wl_sign, ONE << e, v_init[e]);
          end
          checks++;
          if ((last_vul < 0) ? (k != 3) : (k - last_vul != 5)) begin
            failures++; $display("FAIL sweep_vul_timing got cycle=%0d prev=%0d exp gap=5 first=3", k, last_vul);
          end
          last_vul = k;
        end
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || k != 21) begin failures++; $display("FAIL sweep_done got cycle=%0d done=%0b exp=21", k, got_done); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sweep_missing_vul got_left=%0d exp=0", exp_q.size()); end
    checks++;
    if (v !== (v_init ^ 60'hF)) begin failures++; $display("FAIL sweep_v got=%h exp=%h", v, v_init ^ 60'hF); end
    checks++;
    if (solved !== 1'b0 || iter_cnt !== 16'd1) begin
      failures++; $display("FAIL sweep_result got solved=%b iter=%0d exp 0/1", solved, iter_cnt);
    end
    $display("sweep: 4 vars, done at cycle %0d v=%h iter=%0d", k, v, iter_cnt);
  endtask

  task automatic test_mid_solve();
    int k = 0;
    int arm = 0;
    int e;
    bit got_done = 0;
    v_init = 60'h0F0_F0F0_1234_5678; var_num = 6'd60; max_iter = 16'd3; satisfy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 18; i++) exp_q.push_back(i);
    pulse_start();
    while (!got_done && k < 300) begin
      @(negedge clk); k++;
      if (arm > 0) begin
        arm--;
        if (arm == 0) begin
          satisfy = 1'b1;
          checks++;
          if (wl_sw !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_check_state got row=%h busy=%b exp 0/1", wl_sw, busy);
          end
        end
      end
      if (vul_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL mid_extra_vul got_row=%h exp=none", wl_sw);
        end else begin
          e = exp_q.pop_front();
          if (wl_sw !== (ONE << e)) begin failures++; $display("FAIL mid_row got=%h exp=%h", wl_sw, ONE << e); end
          if (e == 17) arm = 2;
        end
      end
      if (done) got_done = 1;
    end
    satisfy = 1'b0;
    checks++;
    if (!got_done) begin failures++; $display("FAIL mid_timeout got done=0 exp=1"); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL mid_missing_vul got_left=%0d exp=0", exp_q.size()); end
    checks++;
    if (v !== (v_init ^ 60'h3FFFF)) begin failures++; $display("FAIL mid_v got=%h exp=%h", v, v_init ^ 60'h3FFFF); end
    checks++;
    if (solved !== 1'b1 || iter_cnt !== '0) begin
      failures++; $display("FAIL mid_result got solved=%b iter=%0d exp 1/0", solved, iter_cnt);
    end
    $display("mid_solve: solved after idx 17, v=%h", v);
  endtask

  task automatic test_abort();
    int k = 0;
    int e;
    bit hit = 0;
    bit saw_done = 0;
    bit got_done = 0;
    logic [NV-1:0] v_second;
    // START and ABORT together in IDLE: nothing starts.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wl_sw !== '0) begin failures++; $display("FAIL abort_start_idle got busy=%b exp=0", busy); end
    v_init = 60'hFED_CBA9_8765_4321; var_num = 6'd60; max_iter = '0; satisfy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(i);
    pulse_start();
    while (!hit && k < 100) begin
      @(negedge clk); k++;
      if (vul_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL abort_extra_vul got_row=%h exp=none", wl_sw);
        end else begin
          e = exp_q.pop_front();
          if (wl_sw !== (ONE << e)) begin failures++; $display("FAIL abort_row got=%h exp=%h", wl_sw, ONE << e); end
          if (e == 5) begin abort = 1'b1; hit = 1; end
        end
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_timeout got idx5=0 exp=1"); end
    @(negedge clk) abort = 1'b0;
    checks++;
    if (vul_en !== 1'b0 || wl_sw !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_idle got vul=%b row=%h busy=%b done=%b exp all 0", vul_en, wl_sw, busy, done);
    end
    checks++;
    if (sram_state !== 1'b1 || solved !== 1'b0) begin
      failures++; $display("FAIL abort_flags got sram=%b solved=%b exp 1/0", sram_state, solved);
    end
    checks++;
    if (v !== (v_init ^ 60'h1F)) begin failures++; $display("FAIL abort_v got=%h exp=%h", v, v_init ^ 60'h1F); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin failures++; $display("FAIL abort_no_done got done=1 exp=0"); end
    // A fresh START after abort reloads V from the new V_INIT.
    v_second = 60'h00F_0000_0000_0ABC;
    v_init = v_second; satisfy = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (v !== v_second) begin failures++; $display("FAIL abort_reload got=%h exp=%h", v, v_second); end
    k = 0;
    while (!got_done && k < 20) begin
      @(negedge clk); k++;
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || solved !== 1'b1) begin failures++; $display("FAIL abort_restart got done=%b solved=%b exp 1/1", got_done, solved); end
    satisfy = 1'b0;
    $display("abort: aborted at idx 5, restart v=%h solved=%0b", v, solved);
  endtask

  task automatic test_reset_busy();
    int k = 2;
    int last_vul = -1;
    int e;
    bit hit = 0;
    v_init = 60'h333_3333_3333_3333; var_num = 6'd4; max_iter = '0; satisfy = 1'b0;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!hit && k < 50) begin
      @(negedge clk); k++;
      if (vul_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL busy_extra_vul got_row=%h exp=none", wl_sw);
        end else begin
          e = exp_q.pop_front();
          if (wl_sw !== (ONE << e) || ((last_vul < 0) ? (k != 3) : (k - last_vul != 5))) begin
            failures++; $display("FAIL busy_start_ignored got row=%h cycle=%0d exp row=%h", wl_sw, k, ONE << e);
          end
          last_vul = k;
          if (e == 1) hit = 1;
        end
      end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL busy_timeout got idx1=0 exp=1"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v !== '0 || wl_sw !== '0) begin failures++; $display("FAIL async_reset_vec got v=%h row=%h exp 0/0", v, wl_sw); end
    checks++;
    if ({wl_sign, vul_en, v_pre, var_state, busy, done, solved} !== 7'b0 || sram_state !== 1'b1 || iter_cnt !== '0) begin
      failures++;
      $display("FAIL async_reset_flags got=%b sram=%b iter=%0d exp 0000000/1/0",
               {wl_sign, vul_en, v_pre, var_state, busy, done, solved}, sram_state, iter_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wl_sw !== '0) begin failures++; $display("FAIL async_reset_idle got busy=%b exp=0", busy); end
    $display("reset_busy: START ignored in SELECT, async reset in CAPTURE");
  endtask

  task automatic test_var_num_clamp(input logic [5:0] vn, input int mi);
    int k = 0;
    int e;
    bit got_done = 0;
    logic [NV-1:0] v_exp;
    v_init = 60'h9C3_1E77_0B5D_2468; var_num = vn; max_iter = ITER_W'(mi); satisfy = 1'b0;
    exp_q.delete();
    for (int s = 0; s <= mi; s++)
      for (int i = 0; i < NV; i++) exp_q.push_back(i);
    v_exp = ((mi + 1) % 2 == 1) ? (v_init ^ ALL1) : v_init;
    pulse_start();
    while (!got_done && k < 2000) begin
      @(negedge clk); k++;
      if (vul_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL clamp_extra_vul got_row=%h exp=none", wl_sw);
        end else begin
          e = exp_q.pop_front();
          if (wl_sw !== (ONE << e)) begin failures++; $display("FAIL clamp_row got=%h exp=%h", wl_sw, ONE << e); end
        end
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || exp_q.size() != 0) begin
      failures++; $display("FAIL clamp_done got done=%b left=%0d exp 1/0", got_done, exp_q.size());
    end
    checks++;
    if (iter_cnt !== ITER_W'(mi + 1) || solved !== 1'b0) begin
      failures++; $display("FAIL clamp_result got iter=%0d solved=%b exp %0d/0", iter_cnt, solved, mi + 1);
    end
    checks++;
    if (v !== v_exp) begin failures++; $display("FAIL clamp_v got=%h exp=%h", v, v_exp); end
    $display("var_num_clamp: var_num=%0d max_iter=%0d done at cycle %0d iter=%0d", vn, mi, k, iter_cnt);
  endtask

  initial begin
    test_reset();
    test_presat();
    test_sweep();
    test_mid_solve();
    test_abort();
    test_reset_busy();
    test_var_num_clamp(6'd0, 1);
    test_var_num_clamp(6'd61, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vpe_var_sweep_ctrl.md
Name: vpe_var_sweep_ctrl

Overview:
- Upstream sequencer for the VPE slave array.
- Holds the 60-bit variable assignment vector V and sweeps variables one at a time: selects the variable row, lets the clause adder tree settle, pulses the variable-update enable, then writes the returned VI_READOUT back into V.
- Checks the systolic SATISFY result after every update. Stops when the formula is solved or the iteration budget runs out.

Parameters:
- NV, 60, number of variables (width of V and WL_SW).
- ITER_W, 16, width of the sweep-iteration counter and limit.
- SETTLE, 2, cycles WL_SW is held before VUL_EN (adder tree plus C_VAR_UPD input settling); legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that begins a solve; ignored unless IDLE.
- ABORT  in  1  forces return to IDLE.
- V_INIT  in  NV  initial assignment, sampled on accepted START.
- VAR_NUM  in  6  number of active variables (1..NV), sampled on START.
- MAX_ITER  in  ITER_W  full-sweep limit, sampled on START; 0 means one sweep.
- VI_READOUT  in  1  updated variable value from the slave.
- SATISFY  in  1  systolic all-clauses-satisfied flag from the slave.
- V  out  NV  current assignment, drives slave V.
- WL_SW  out  NV  one-hot row select of the current variable; zero when not selecting.
- WL_SIGN  out  1  current value V[idx] while selecting, else 0.
- VUL_EN  out  1  single-cycle variable-update enable.
- V_PRE  out  1  previous value of the variable under update.
- VAR_STATE  out  1  high while BUSY (variable-update mode).
- SRAM_STATE  out  1  low while BUSY; high in IDLE and DONE (SRAM access allowed).
- BUSY  out  1  solve in progress.
- DONE  out  1  one-cycle pulse at end of solve.
- SOLVED  out  1  result flag, valid from DONE until the next START.
- ITER_CNT  out  ITER_W  completed full sweeps.

Behaviour:
- Reset values: V=0, WL_SW=0, WL_SIGN=0, VUL_EN=0, V_PRE=0, VAR_STATE=0, SRAM_STATE=1, BUSY=0, DONE=0, SOLVED=0, ITER_CNT=0. State is IDLE, idx=0, settle counter=0.
- FSM states: IDLE, LOAD, SELECT, UPDATE, CAPTURE, CHECK, FIN.
- IDLE: START=1 moves to LOAD. V_INIT, VAR_NUM and MAX_ITER are latched; ITER_CNT and SOLVED are cleared.
- LOAD: V<=V_INIT, idx<=0, then go to SELECT.
- SELECT:
  - WL_SW=1<<idx, WL_SIGN=V[idx], held for SETTLE cycles, then go to UPDATE.
  - The first SELECT after LOAD checks SATISFY on its last settle cycle. If it is 1, go directly to FIN with SOLVED=1, because the initial assignment already satisfies the formula.
- UPDATE: WL_SW held, VUL_EN=1 for exactly one cycle, V_PRE=V[idx], then go to CAPTURE.
- CAPTURE: WL_SW held, V[idx]<=VI_READOUT, then go to CHECK. Other bits of V never change.
- CHECK: WL_SW=0. Priority order:
  1. SATISFY=1: SOLVED<=1, go to FIN.
  2. idx==VAR_NUM-1: idx<=0, ITER_CNT+=1. If the new ITER_CNT > MAX_ITER, go to FIN with SOLVED=0; otherwise go to SELECT.
  3. Otherwise: idx+=1, go to SELECT.
- FIN: DONE=1 for one cycle, BUSY falls in the same cycle, then go to IDLE.
- BUSY=1 in LOAD through CHECK. VAR_STATE=BUSY and SRAM_STATE=~BUSY, both registered.
- Per-variable cost: SETTLE+3 cycles.
- ABORT takes precedence over all transitions. From any non-IDLE state, next state is IDLE with WL_SW=0 and VUL_EN=0. No DONE pulse; SOLVED=0; V keeps its last value.
- START while BUSY is ignored.
- START and ABORT together in IDLE: ABORT wins, state stays IDLE.
- VAR_NUM=0 or VAR_NUM>NV is treated as NV.
- ITER_CNT saturates at all-ones. MAX_ITER=all-ones can still terminate only on SATISFY.
- Async reset mid-operation returns all outputs to reset values immediately.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit enum).
  - NV, ITER_W and SETTLE defaults.
  - Function onehot_sel(idx) returning an NV-bit vector.
- Natural sub-module: vpe_var_reg. It holds the NV-bit V register with parallel load (V_INIT) and single-bit write (idx, VI_READOUT), and provides the V[idx] read mux.
- The FSM, counters and output decode stay in the top.

Test Plan:
- Reset release, then idle 5 cycles: all outputs at reset values, SRAM_STATE=1.
- Initial assignment already satisfying: V_INIT=0x123, SATISFY tied 1, START → SELECT at idx 0, FIN without any VUL_EN, DONE pulse, SOLVED=1, ITER_CNT=0, V=0x123.
- Sweep order and timing: VAR_NUM=4, SETTLE=2, SATISFY=0, MAX_ITER=0.
  - Model returns VI_READOUT=~V_PRE.
  - Expect WL_SW 0x1,0x2,0x4,0x8, each asserted for 4 consecutive cycles.
  - VUL_EN pulses 5 cycles apart.
  - Final V = V_INIT^0xF, DONE with SOLVED=0, ITER_CNT=1.
- Solve mid-sweep: VAR_NUM=60, SATISFY raised in the CHECK after idx 17 → V bits 18..59 unchanged, SOLVED=1, ITER_CNT=0.
- ABORT during UPDATE at idx 5 → next cycle IDLE, VUL_EN=0, WL_SW=0, no DONE. A subsequent START reloads V_INIT.
- Async reset asserted during CAPTURE (mid-cycle) → outputs at reset values before the next clock edge. START is ignored while BUSY, verified by pulsing START during SELECT.
